// File: rtl/dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_access_ctrl
//   Data-memory transaction controller sitting after the memory-access stage.
//   Accepts one load or store at a time, drives a ready/valid memory port with
//   word address, byte lanes and lane-replicated store data, and returns an
//   aligned, sign/zero-extended load result. The pipeline is stalled until the
//   access completes, so memory latency may vary freely.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   i_valid             memory op presented this cycle
//   i_ren / i_wen       load / store request (store wins when both are high)
//   i_addr              byte address
//   i_wdata             store data
//   i_funct3            size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   o_stall             pipeline must hold its inputs
//   o_load_data         aligned, extended load result (held until next load)
//   o_load_valid        one-cycle pulse when a load completes
//   o_fault             one-cycle pulse for misaligned access / illegal funct3
//   o_mem_req_valid     request valid towards memory
//   i_mem_req_ready     memory accepts the request
//   o_mem_addr          word-aligned address
//   o_mem_wen           1 = write
//   o_mem_wdata         lane-replicated store data
//   o_mem_mask          byte enables (0000 for loads)
//   i_mem_rsp_valid     read data valid
//   i_mem_rsp_rdata     read word
// ----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_ren,
    input  logic              i_wen,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [2:0]        i_funct3,
    output logic              o_stall,
    output logic [XLEN-1:0]   o_load_data,
    output logic              o_load_valid,
    output logic              o_fault,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [XLEN-1:0]   o_mem_wdata,
    output logic [3:0]        o_mem_mask,
    input  logic              i_mem_rsp_valid,
    input  logic [XLEN-1:0]   i_mem_rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Lane helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] m;
        case (f3[1:0])
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] r;
        case (f3[1:0])
            2'b00:   r = {4{wd[7:0]}};
            2'b01:   r = {2{wd[15:0]}};
            default: r = wd;
        endcase
        return r;
    endfunction

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                                     input logic [XLEN-1:0] rd);
        logic signed [7:0]      b;
        logic signed [15:0]     h;
        logic signed [XLEN-1:0] ext;
        logic [XLEN-1:0]        r;
        b = rd[{lo, 3'b000} +: 8];
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  begin ext = XLEN'(b); r = ext; end
            3'b001:  begin ext = XLEN'(h); r = ext; end
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    state_t state_q, state_d;

    logic is_access;
    logic legal;
    logic aligned;
    logic accept;
    logic bad_req;

    always_comb begin
        is_access = i_valid & (i_ren | i_wen);
        // Unsigned loads have no store counterpart; 011/11x are reserved.
        case (i_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~i_wen;
            default:                legal = 1'b0;
        endcase
        case (i_funct3[1:0])
            2'b01:   aligned = ~i_addr[0];
            2'b10:   aligned = (i_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        accept  = (state_q == S_IDLE) & is_access & legal & aligned;
        bad_req = (state_q == S_IDLE) & is_access & ~(legal & aligned);
    end

    // ------------------------------------------------------------------
    // Captured transaction
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        lo_q;
    logic [2:0]        funct3_q;
    logic              wen_q;
    logic [XLEN-1:0]   wdata_q;
    logic [3:0]        mask_q;
    logic [XLEN-1:0]   load_data_q;
    logic              fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            lo_q        <= '0;
            funct3_q    <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            mask_q      <= '0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= bad_req;
            if (accept) begin
                addr_q   <= {i_addr[ADDR_W-1:2], 2'b00};
                lo_q     <= i_addr[1:0];
                funct3_q <= i_funct3;
                wen_q    <= i_wen;
                wdata_q  <= i_wen ? store_lanes(i_funct3, i_wdata) : '0;
                mask_q   <= i_wen ? store_mask(i_funct3, i_addr[1:0]) : 4'b0000;
            end
            if ((state_q == S_WAIT) && i_mem_rsp_valid) begin
                load_data_q <= load_extract(funct3_q, lo_q, i_mem_rsp_rdata);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs; req_valid and stall come
    // straight from the state so reset drops them without waiting a clock.
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        o_stall         = 1'b0;
        o_mem_req_valid = 1'b0;
        o_load_valid    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_REQ;
                    o_stall = 1'b1;
                end
            end
            S_REQ: begin
                o_stall         = 1'b1;
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    state_d = wen_q ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                o_stall = 1'b1;
                if (i_mem_rsp_valid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_load_valid = ~wen_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_mem_addr  = addr_q;
    assign o_mem_wen   = wen_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_mask  = mask_q;
    assign o_load_data = load_data_q;
    assign o_fault     = fault_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//   Directed, table-driven bench for dmem_access_ctrl. Each table row is one
//   complete transaction with hand-computed expected lanes and load result;
//   reset-in-flight and idle behaviour are covered by explicit sequences.
// ----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        i_ren;
    logic        i_wen;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [2:0]  i_funct3;
    logic        o_stall;
    logic [31:0] o_load_data;
    logic        o_load_valid;
    logic        o_fault;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_rdata;

    dmem_access_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (i_valid),
        .i_ren           (i_ren),
        .i_wen           (i_wen),
        .i_addr          (i_addr),
        .i_wdata         (i_wdata),
        .i_funct3        (i_funct3),
        .o_stall         (o_stall),
        .o_load_data     (o_load_data),
        .o_load_valid    (o_load_valid),
        .o_fault         (o_fault),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wen       (o_mem_wen),
        .o_mem_wdata     (o_mem_wdata),
        .o_mem_mask      (o_mem_mask),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rsp_rdata (i_mem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        int          rsp_dly;
        int          rdy_dly;
        logic        fault;
        logic [3:0]  mask;
        logic [31:0] mwdata;
        logic [31:0] maddr;
        logic [31:0] ldata;
    } vec_t;

    localparam int NV = 21;
    vec_t tv [0:NV-1];

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] last_ld = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input vec_t v, input int idx, input string tag);
        chk($sformatf("v%0d %s req_valid", idx, tag), 32'(o_mem_req_valid), 32'd1);
        chk($sformatf("v%0d %s stall", idx, tag), 32'(o_stall), 32'd1);
        chk($sformatf("v%0d %s addr", idx, tag), o_mem_addr, v.maddr);
        chk($sformatf("v%0d %s mask", idx, tag), 32'(o_mem_mask), 32'(v.mask));
        chk($sformatf("v%0d %s wen", idx, tag), 32'(o_mem_wen), 32'(v.wen));
        if (v.wen) chk($sformatf("v%0d %s wdata", idx, tag), o_mem_wdata, v.mwdata);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        i_valid  = 1'b1;
        i_ren    = v.ren;
        i_wen    = v.wen;
        i_funct3 = v.f3;
        i_addr   = v.addr;
        i_wdata  = v.wdata;
        i_mem_req_ready = 1'b0;
        #1;
        if (v.fault) begin
            chk($sformatf("v%0d flt stall", idx), 32'(o_stall), 32'd0);
            chk($sformatf("v%0d flt req0", idx), 32'(o_mem_req_valid), 32'd0);
            tick();
            i_valid = 1'b0; i_ren = 1'b0; i_wen = 1'b0;
            #1;
            chk($sformatf("v%0d fault pulse", idx), 32'(o_fault), 32'd1);
            chk($sformatf("v%0d flt req1", idx), 32'(o_mem_req_valid), 32'd0);
            chk($sformatf("v%0d flt stall1", idx), 32'(o_stall), 32'd0);
            tick();
            chk($sformatf("v%0d fault end", idx), 32'(o_fault), 32'd0);
            chk($sformatf("v%0d flt req2", idx), 32'(o_mem_req_valid), 32'd0);
            chk($sformatf("v%0d flt ldata", idx), o_load_data, last_ld);
            return;
        end
        // accept cycle
        chk($sformatf("v%0d acc stall", idx), 32'(o_stall), 32'd1);
        chk($sformatf("v%0d acc req", idx), 32'(o_mem_req_valid), 32'd0);
        chk($sformatf("v%0d acc fault", idx), 32'(o_fault), 32'd0);
        tick();
        chk_req(v, idx, "req");
        // back-pressure; a stray response here must not move the FSM
        for (int k = 0; k < v.rdy_dly; k++) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_rdata = 32'hCAFEF00D;
            tick();
            i_mem_rsp_valid = 1'b0;
            chk_req(v, idx, $sformatf("hold%0d", k));
        end
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        if (!v.wen) begin
            chk($sformatf("v%0d wait stall", idx), 32'(o_stall), 32'd1);
            chk($sformatf("v%0d wait req", idx), 32'(o_mem_req_valid), 32'd0);
            for (int k = 0; k < v.rsp_dly; k++) begin
                tick();
                chk($sformatf("v%0d wait%0d stall", idx, k), 32'(o_stall), 32'd1);
            end
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_rdata = v.rsp;
            tick();
            i_mem_rsp_valid = 1'b0;
        end
        // DONE
        chk($sformatf("v%0d done stall", idx), 32'(o_stall), 32'd0);
        chk($sformatf("v%0d done lvalid", idx), 32'(o_load_valid), 32'(!v.wen));
        chk($sformatf("v%0d done req", idx), 32'(o_mem_req_valid), 32'd0);
        if (!v.wen) begin
            chk($sformatf("v%0d ldata", idx), o_load_data, v.ldata);
            last_ld = v.ldata;
        end else begin
            chk($sformatf("v%0d ldata hold", idx), o_load_data, last_ld);
        end
        i_valid = 1'b0; i_ren = 1'b0; i_wen = 1'b0;
        tick();
        chk($sformatf("v%0d idle lvalid", idx), 32'(o_load_valid), 32'd0);
        chk($sformatf("v%0d idle stall", idx), 32'(o_stall), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"},  32'(o_stall), 32'd0);
        chk({tag, " ldata"},  o_load_data, 32'd0);
        chk({tag, " lvalid"}, 32'(o_load_valid), 32'd0);
        chk({tag, " fault"},  32'(o_fault), 32'd0);
        chk({tag, " req"},    32'(o_mem_req_valid), 32'd0);
        chk({tag, " addr"},   o_mem_addr, 32'd0);
        chk({tag, " wen"},    32'(o_mem_wen), 32'd0);
        chk({tag, " wdata"},  o_mem_wdata, 32'd0);
        chk({tag, " mask"},   32'(o_mem_mask), 32'd0);
    endtask

    initial begin
        //          ren  wen  f3      addr          wdata         rsp           rd ry flt mask     mwdata        maddr         ldata
        tv[0]  = '{1'b0,1'b1,3'b010,32'h0000_0100,32'hDEAD_BEEF,32'h0,        0, 0, 1'b0,4'b1111,32'hDEAD_BEEF,32'h0000_0100,32'h0};
        tv[1]  = '{1'b0,1'b1,3'b000,32'h0000_0103,32'h0000_00A5,32'h0,        0, 0, 1'b0,4'b1000,32'hA5A5_A5A5,32'h0000_0100,32'h0};
        tv[2]  = '{1'b0,1'b1,3'b001,32'h0000_0202,32'h1234_ABCD,32'h0,        0, 4, 1'b0,4'b1100,32'hABCD_ABCD,32'h0000_0200,32'h0};
        tv[3]  = '{1'b0,1'b1,3'b001,32'h0000_0200,32'h1234_ABCD,32'h0,        0, 0, 1'b0,4'b0011,32'hABCD_ABCD,32'h0000_0200,32'h0};
        tv[4]  = '{1'b0,1'b1,3'b000,32'h0000_0001,32'h7777_7711,32'h0,        0, 0, 1'b0,4'b0010,32'h1111_1111,32'h0000_0000,32'h0};
        tv[5]  = '{1'b1,1'b0,3'b000,32'h0000_0102,32'h0,        32'h80FF_7F00,3, 0, 1'b0,4'b0000,32'h0,        32'h0000_0100,32'hFFFF_FFFF};
        tv[6]  = '{1'b1,1'b0,3'b100,32'h0000_0102,32'h0,        32'h80FF_7F00,0, 0, 1'b0,4'b0000,32'h0,        32'h0000_0100,32'h0000_00FF};
        tv[7]  = '{1'b0,1'b1,3'b010,32'h0000_0300,32'h0102_0304,32'h0,        0, 0, 1'b0,4'b1111,32'h0102_0304,32'h0000_0300,32'h0};
        tv[8]  = '{1'b1,1'b0,3'b000,32'h0000_0101,32'h0,        32'h80FF_7F00,1, 0, 1'b0,4'b0000,32'h0,        32'h0000_0100,32'h0000_007F};
        tv[9]  = '{1'b1,1'b0,3'b001,32'h0000_0102,32'h0,        32'h80FF_7F00,0, 2, 1'b0,4'b0000,32'h0,        32'h0000_0100,32'hFFFF_80FF};
        tv[10] = '{1'b1,1'b0,3'b101,32'h0000_0102,32'h0,        32'h80FF_7F00,0, 0, 1'b0,4'b0000,32'h0,        32'h0000_0100,32'h0000_80FF};
        tv[11] = '{1'b1,1'b0,3'b001,32'h0000_0100,32'h0,        32'h80FF_7F00,0, 0, 1'b0,4'b0000,32'h0,        32'h0000_0100,32'h0000_7F00};
        tv[12] = '{1'b1,1'b0,3'b010,32'h0000_0104,32'h0,        32'h80FF_7F00,2, 0, 1'b0,4'b0000,32'h0,        32'h0000_0104,32'h80FF_7F00};
        tv[13] = '{1'b1,1'b0,3'b000,32'h0000_0103,32'h0,        32'h80FF_7F00,0, 0, 1'b0,4'b0000,32'h0,        32'h0000_0100,32'hFFFF_FF80};
        tv[14] = '{1'b1,1'b1,3'b010,32'h0000_0108,32'h5555_AAAA,32'h0,        0, 0, 1'b0,4'b1111,32'h5555_AAAA,32'h0000_0108,32'h0};
        tv[15] = '{1'b1,1'b0,3'b001,32'h0000_0101,32'h0,        32'h0,        0, 0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};
        tv[16] = '{1'b0,1'b1,3'b010,32'h0000_0102,32'h1111_2222,32'h0,        0, 0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};
        tv[17] = '{1'b1,1'b0,3'b010,32'h0000_0101,32'h0,        32'h0,        0, 0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};
        tv[18] = '{1'b0,1'b1,3'b100,32'h0000_0100,32'h0000_0033,32'h0,        0, 0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};
        tv[19] = '{1'b1,1'b0,3'b011,32'h0000_0100,32'h0,        32'h0,        0, 0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};
        tv[20] = '{1'b0,1'b1,3'b001,32'h0000_0103,32'h0000_BEEF,32'h0,        0, 0, 1'b1,4'b0000,32'h0,        32'h0,        32'h0};

        rst_n = 1'b0;
        i_valid = 1'b0; i_ren = 1'b0; i_wen = 1'b0;
        i_addr = 32'h0; i_wdata = 32'h0; i_funct3 = 3'b000;
        i_mem_req_ready = 1'b0; i_mem_rsp_valid = 1'b0; i_mem_rsp_rdata = 32'h0;
        #12;
        chk_all_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_vec(tv[i], i);
        end

        // op presented with neither enable, then enables without i_valid
        i_valid = 1'b1; i_ren = 1'b0; i_wen = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0101;
        #1;
        chk("noen stall", 32'(o_stall), 32'd0);
        tick();
        chk("noen req", 32'(o_mem_req_valid), 32'd0);
        chk("noen fault", 32'(o_fault), 32'd0);
        i_valid = 1'b0; i_ren = 1'b1; i_wen = 1'b1;
        #1;
        chk("novld stall", 32'(o_stall), 32'd0);
        tick();
        chk("novld req", 32'(o_mem_req_valid), 32'd0);
        chk("novld fault", 32'(o_fault), 32'd0);
        i_ren = 1'b0; i_wen = 1'b0;
        tick();

        // reset while waiting for a load response
        i_valid = 1'b1; i_ren = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_010C;
        tick();
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        chk("rw wait stall", 32'(o_stall), 32'd1);
        chk("rw prior ldata", o_load_data, last_ld);
        #2;
        rst_n = 1'b0;
        i_valid = 1'b0; i_ren = 1'b0;
        #1;
        chk_all_zero("rst in wait");
        tick();
        rst_n = 1'b1;
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_rdata = 32'h1234_5678;
        tick();
        i_mem_rsp_valid = 1'b0;
        chk("late rsp lvalid", 32'(o_load_valid), 32'd0);
        chk("late rsp ldata", o_load_data, 32'd0);
        chk("late rsp stall", 32'(o_stall), 32'd0);
        tick();
        chk("late rsp lvalid2", 32'(o_load_valid), 32'd0);
        chk("late rsp ldata2", o_load_data, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
